// File: rtl/tsn_qm_pkg.sv
// Shared definitions for the TSN queue manager: widths, frame-type gating
// threshold, dequeue FSM encodings, status codes and BM address arithmetic.
package tsn_qm_pkg;

    // BM offset bits inside one queue region; the bits above are the region
    localparam int REGION_W = 11;
    localparam int ADDR_W   = 16;
    localparam int LEN_W    = 11;
    localparam int QUEUE_W  = 8;

    // Frame types (queue_number[2:0]) at or above this value are CQF-gated
    localparam logic [2:0] CYCLIC_T0 = 3'd6;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RD_QINFO   = 4'd1,
        ST_WAIT_QINFO = 4'd2,
        ST_RD_DESC    = 4'd3,
        ST_WAIT_DESC  = 4'd4,
        ST_STREAM     = 4'd5,
        ST_WR_UPDATE  = 4'd6,
        ST_FINISH     = 4'd7,
        ST_FAIL       = 4'd8
    } deq_state_e;

    typedef enum logic [1:0] {
        DEQ_OK    = 2'b00,
        DEQ_EMPTY = 2'b01,
        DEQ_GATE  = 2'b10,
        DEQ_ERR   = 2'b11
    } deq_status_e;

    // Advance a BM address by inc blocks. The offset wraps inside its
    // region; the region bits are carried through untouched.
    function automatic logic [ADDR_W-1:0] bm_addr_wrap(
        input logic [ADDR_W-1:0] addr,
        input logic [LEN_W-1:0]  inc
    );
        logic [REGION_W-1:0] off;
        off = addr[REGION_W-1:0] + REGION_W'(inc);
        return {addr[ADDR_W-1:REGION_W], off};
    endfunction

endpackage

// File: rtl/dequeue_bm_streamer.sv
// Beat counter and BM address generator for the STREAM phase of a dequeue.
// Loaded with the head BM address and frame length, it presents one BM
// address per beat and advances only on a valid/ready handshake, so the
// address and the sop/eop flags hold steady while the transmit engine stalls.
module dequeue_bm_streamer
    import tsn_qm_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    input  logic              active,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [ADDR_W-1:0] tx_addr,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              last_beat
);

    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  beat_r;
    logic [LEN_W-1:0]  len_r;
    logic              hs;

    assign hs = active & tx_ready;

    // Load on start, then step address and beat index once per handshake
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            beat_r <= '0;
            len_r  <= '0;
        end else if (start) begin
            addr_r <= start_addr;
            beat_r <= '0;
            len_r  <= start_len;
        end else if (hs) begin
            addr_r <= bm_addr_wrap(addr_r, LEN_W'(1));
            beat_r <= beat_r + 1'b1;
        end
    end

    // Beat flags come from the registered index, so a stall cannot move them
    always_comb begin
        tx_valid  = active;
        tx_addr   = addr_r;
        tx_sop    = active & (beat_r == '0);
        tx_eop    = active & (beat_r == len_r - 1'b1);
        last_beat = hs & tx_eop;
    end

endmodule

// File: rtl/dequeue_logic.sv
// Dequeue admission and BM streaming for the TSN queue manager.
// A scheduler request reads the queue-info entry, rejects empty queues and
// closed CQF gates, reads the head-frame descriptor, streams the frame's BM
// addresses to the transmit engine and finally writes back the new front
// pointer, the remaining BM count and the number of BMs freed.
module dequeue_logic
    import tsn_qm_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        deq_req,
    input  logic [7:0]  deq_queue,
    output logic        deq_rdy,
    output logic        deq_done,
    output logic [1:0]  deq_status,
    input  logic [1:0]  gate_open,
    output logic        qi_rd_en,
    output logic [7:0]  qi_rd_queue,
    input  logic [15:0] qi_front,
    input  logic [10:0] qi_bm_num,
    output logic        desc_rd_en,
    output logic [15:0] desc_addr,
    input  logic [10:0] desc_len,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_addr,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        upd_valid,
    output logic [31:0] front_update,
    output logic [10:0] bm_num_update,
    output logic [10:0] free_inc
);

    deq_state_e        state;
    deq_state_e        state_nxt;
    deq_status_e       status_r;
    deq_status_e       status_nxt;

    logic [QUEUE_W-1:0] queue_r;
    logic [ADDR_W-1:0]  front_r;
    logic [LEN_W-1:0]   bm_num_r;
    logic [LEN_W-1:0]   len_r;
    logic [ADDR_W-1:0]  new_front;

    logic               cyclic;
    logic               gate_bit;
    logic               stream_active;
    logic               stream_start;
    logic               stream_last;

    // Cyclic types map onto gate_open bits starting at CYCLIC_T0
    assign cyclic    = (queue_r[2:0] >= CYCLIC_T0);
    assign gate_bit  = |(gate_open & (2'b01 << (queue_r[2:0] - CYCLIC_T0)));
    assign new_front = bm_addr_wrap(front_r, len_r);

    // State register; reset aborts any frame in flight
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and completion status selection
    always_comb begin
        state_nxt  = state;
        status_nxt = status_r;
        unique case (state)
            ST_IDLE: begin
                if (deq_req) begin
                    state_nxt  = ST_RD_QINFO;
                    status_nxt = DEQ_OK;
                end
            end
            ST_RD_QINFO: state_nxt = ST_WAIT_QINFO;
            ST_WAIT_QINFO: begin
                // Queue info arrives this cycle, so decide on the live inputs
                if (qi_bm_num == '0) begin
                    state_nxt  = ST_FAIL;
                    status_nxt = DEQ_EMPTY;
                end else if (cyclic && !gate_bit) begin
                    state_nxt  = ST_FAIL;
                    status_nxt = DEQ_GATE;
                end else begin
                    state_nxt = ST_RD_DESC;
                end
            end
            ST_RD_DESC: state_nxt = ST_WAIT_DESC;
            ST_WAIT_DESC: begin
                // A frame longer than the queue's BM count means corrupt metadata
                if (desc_len == '0 || desc_len > bm_num_r) begin
                    state_nxt  = ST_FAIL;
                    status_nxt = DEQ_ERR;
                end else begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (stream_last) begin
                    state_nxt = ST_WR_UPDATE;
                end
            end
            ST_WR_UPDATE: state_nxt = ST_FINISH;
            ST_FINISH:    state_nxt = ST_IDLE;
            ST_FAIL:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded strobes and the gated write-back/status buses
    always_comb begin
        deq_rdy       = 1'b0;
        qi_rd_en      = 1'b0;
        desc_rd_en    = 1'b0;
        upd_valid     = 1'b0;
        deq_done      = 1'b0;
        stream_active = 1'b0;
        unique case (state)
            ST_IDLE:      deq_rdy       = 1'b1;
            ST_RD_QINFO:  qi_rd_en      = 1'b1;
            ST_RD_DESC:   desc_rd_en    = 1'b1;
            ST_STREAM:    stream_active = 1'b1;
            ST_WR_UPDATE: upd_valid     = 1'b1;
            ST_FINISH:    deq_done      = 1'b1;
            ST_FAIL:      deq_done      = 1'b1;
            default:      deq_rdy       = 1'b0;
        endcase
        stream_start  = (state == ST_WAIT_DESC) && (state_nxt == ST_STREAM);
        qi_rd_queue   = queue_r;
        desc_addr     = front_r;
        deq_status    = deq_done ? status_r : DEQ_OK;
        front_update  = upd_valid ? {8'h00, queue_r, new_front} : '0;
        bm_num_update = upd_valid ? (bm_num_r - len_r) : '0;
        free_inc      = upd_valid ? len_r : '0;
    end

    // Request, queue-info and descriptor fields latched as each phase completes
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            queue_r  <= '0;
            front_r  <= '0;
            bm_num_r <= '0;
            len_r    <= '0;
            status_r <= DEQ_OK;
        end else begin
            status_r <= status_nxt;
            if (state == ST_IDLE && deq_req) begin
                queue_r <= deq_queue;
            end
            if (state == ST_WAIT_QINFO) begin
                front_r  <= qi_front;
                bm_num_r <= qi_bm_num;
            end
            if (state == ST_WAIT_DESC) begin
                len_r <= desc_len;
            end
        end
    end

    dequeue_bm_streamer u_streamer (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .start      (stream_start),
        .start_addr (front_r),
        .start_len  (desc_len),
        .active     (stream_active),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_addr    (tx_addr),
        .tx_sop     (tx_sop),
        .tx_eop     (tx_eop),
        .last_beat  (stream_last)
    );

endmodule
